cu_instr_sequencer: RTL and testbench

Initiator-side driver for the compute unit's instruction bus. It feeds the compute unit's ui_in (opcode/address byte) and uio_in (operand byte).
A host preloads a short program of {op, operand} byte pairs into an internal buffer. On start, the block replays the program to the compute unit, one instruction per HOLD_CYCLES clocks. It then captures the unit's uo_out and signals done.
It sits between the chip-level host interface and the compute unit, replacing hand-driven stimulus.

---
 rtl/cu_instr_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cu_instr_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_instr_sequencer.sv
// Purpose : replays a preloaded {op, operand} program onto the compute unit's ui_in/uio_in bus, then captures uo_out.
// Latency : first instruction on the bus one clock after start; each entry is held HOLD_CYCLES clocks; done one clock after the last entry.
// Backpr. : wr_ready drops while not IDLE or when the buffer is full (writes then dropped); ena=0 freezes every register.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global enable, 0 holds all state and outputs
//   wr_valid/wr_ready   program write handshake, wr_op -> cu_ui, wr_data -> cu_uio
//   clear               empty the program buffer (IDLE only, beats a same-cycle write)
//   start               level-sampled replay request (IDLE only)
//   cu_ui/cu_uio        instruction bus to the compute unit, cu_valid marks a program entry
//   cu_uo               compute unit output, captured into result on leaving DONE
//   busy/done           replay in progress / one-cycle end-of-replay pulse
//   count               number of loaded entries
module cu_instr_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_valid,
    input  logic [7:0]              wr_op,
    input  logic [7:0]              wr_data,
    output logic                    wr_ready,
    input  logic                    clear,
    input  logic                    start,
    output logic [7:0]              cu_ui,
    output logic [7:0]              cu_uio,
    output logic                    cu_valid,
    input  logic [7:0]              cu_uo,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              result,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int         IW       = $clog2(DEPTH);
    localparam int         CW       = IW + 1;
    localparam logic [3:0] HOLD_RLD = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic [IW-1:0]  r_idx;
    logic [3:0]     r_hold;
    logic [7:0]     r_cu_ui;
    logic [7:0]     r_cu_uio;
    logic           r_cu_valid;
    logic           r_busy;
    logic           r_done;
    logic [7:0]     r_result;
    logic           r_wr_ready;
    logic [15:0]    r_mem [DEPTH];

    state_t         w_state_nxt;
    logic [CW-1:0]  w_count_nxt;
    logic [IW-1:0]  w_idx_nxt;
    logic [IW-1:0]  w_idx_inc;
    logic [3:0]     w_hold_nxt;
    logic [7:0]     w_ui_nxt;
    logic [7:0]     w_uio_nxt;
    logic           w_valid_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic [7:0]     w_result_nxt;
    logic           w_wr_ready_nxt;
    logic           w_wr_acc;

    assign w_idx_inc = r_idx + IW'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_idx_nxt    = r_idx;
        w_hold_nxt   = r_hold;
        w_ui_nxt     = r_cu_ui;
        w_uio_nxt    = r_cu_uio;
        w_valid_nxt  = r_cu_valid;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_wr_acc     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // clear wins over both a write and a start in the same cycle,
                // so a replay never begins against a buffer being emptied.
                if (clear) begin
                    w_count_nxt = '0;
                end else begin
                    if (wr_valid && r_wr_ready && (r_count < CW'(DEPTH))) begin
                        w_wr_acc    = 1'b1;
                        w_count_nxt = r_count + CW'(1);
                    end
                    if (start) begin
                        if (r_count != '0) begin
                            w_state_nxt = S_RUN;
                            {w_ui_nxt, w_uio_nxt} = r_mem[0];
                            w_valid_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                            w_idx_nxt   = '0;
                            w_hold_nxt  = HOLD_RLD;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (r_hold != 4'd0) begin
                    w_hold_nxt = r_hold - 4'd1;
                end else if ((CW'(r_idx) + CW'(1)) < r_count) begin
                    // Next entry follows immediately, no NOP gap between instructions.
                    w_idx_nxt  = w_idx_inc;
                    {w_ui_nxt, w_uio_nxt} = r_mem[w_idx_inc];
                    w_hold_nxt = HOLD_RLD;
                end else begin
                    w_state_nxt = S_DONE;
                    w_ui_nxt    = 8'h00;
                    w_uio_nxt   = 8'h00;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                // The unit has seen NOP for one cycle by now; its output is final.
                w_state_nxt  = S_IDLE;
                w_result_nxt = cu_uo;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // wr_ready is registered from the next state, so it is already correct
    // in the cycle following a state or count change.
    assign w_wr_ready_nxt = (w_state_nxt == S_IDLE) && (w_count_nxt < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_hold     <= 4'd0;
            r_cu_ui    <= 8'h00;
            r_cu_uio   <= 8'h00;
            r_cu_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 8'h00;
            r_wr_ready <= 1'b0;
        end else if (ena) begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_idx      <= w_idx_nxt;
            r_hold     <= w_hold_nxt;
            r_cu_ui    <= w_ui_nxt;
            r_cu_uio   <= w_uio_nxt;
            r_cu_valid <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_result   <= w_result_nxt;
            r_wr_ready <= w_wr_ready_nxt;
        end
    end

    // Program storage has no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (ena && w_wr_acc) begin
            r_mem[r_count[IW-1:0]] <= {wr_op, wr_data};
        end
    end

    assign wr_ready = r_wr_ready;
    assign cu_ui    = r_cu_ui;
    assign cu_uio   = r_cu_uio;
    assign cu_valid = r_cu_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign count    = r_count;

endmodule

// File: tb/tb_cu_instr_sequencer.sv
// Purpose : directed-vector bench for cu_instr_sequencer, one instance with HOLD_CYCLES=1 and one with 3.
// Latency : inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next one.
// Backpr. : the bench waits (bounded) for both instances to return to IDLE between scenarios.
module tb_cu_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       wr_valid;
    logic [7:0] wr_op;
    logic [7:0] wr_data;
    logic       clear;
    logic       start;
    logic [7:0] cu_uo;

    logic       wr_ready,    wr_ready_h3;
    logic [7:0] cu_ui,       cu_ui_h3;
    logic [7:0] cu_uio,      cu_uio_h3;
    logic       cu_valid,    cu_valid_h3;
    logic       busy,        busy_h3;
    logic       done,        done_h3;
    logic [7:0] result,      result_h3;
    logic [3:0] count,       count_h3;

    int n_vec = 0;
    int n_err = 0;

    cu_instr_sequencer #(.DEPTH(8), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_op(wr_op), .wr_data(wr_data), .wr_ready(wr_ready),
        .clear(clear), .start(start),
        .cu_ui(cu_ui), .cu_uio(cu_uio), .cu_valid(cu_valid), .cu_uo(cu_uo),
        .busy(busy), .done(done), .result(result), .count(count)
    );

    cu_instr_sequencer #(.DEPTH(8), .HOLD_CYCLES(3)) dut_h3 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_op(wr_op), .wr_data(wr_data), .wr_ready(wr_ready_h3),
        .clear(clear), .start(start),
        .cu_ui(cu_ui_h3), .cu_uio(cu_uio_h3), .cu_valid(cu_valid_h3), .cu_uo(cu_uo),
        .busy(busy_h3), .done(done_h3), .result(result_h3), .count(count_h3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] op, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_op    = op;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || busy_h3 || done || done_h3) && n < 100) begin
            tick();
            n++;
        end
        check_vec("idle_wait", 32'(busy | busy_h3 | done | done_h3), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        wr_valid = 1'b0;
        wr_op    = 8'h00;
        wr_data  = 8'h00;
        clear    = 1'b0;
        start    = 1'b0;
        cu_uo    = 8'hC9;

        // Reset values
        #12;
        check_vec("rst_ui",       32'(cu_ui),    0);
        check_vec("rst_uio",      32'(cu_uio),   0);
        check_vec("rst_valid",    32'(cu_valid), 0);
        check_vec("rst_count",    32'(count),    0);
        check_vec("rst_wr_ready", 32'(wr_ready), 0);
        check_vec("rst_busy",     32'(busy),     0);
        check_vec("rst_done",     32'(done),     0);
        check_vec("rst_result",   32'(result),   0);
        rst_n = 1'b1;
        tick();
        check_vec("post_rst_wr_ready", 32'(wr_ready), 1);

        // Three-entry program at HOLD_CYCLES=1
        wr(8'h10, 8'h48);
        wr(8'h11, 8'h81);
        wr(8'h22, 8'h01);
        check_vec("load3_count", 32'(count), 3);
        pulse_start();
        check_vec("run_e0", 32'({cu_ui, cu_uio}), 32'h1048);
        check_vec("run_e0_valid", 32'(cu_valid), 1);
        check_vec("run_e0_busy",  32'(busy),     1);
        tick();
        check_vec("run_e1", 32'({cu_ui, cu_uio}), 32'h1181);
        check_vec("run_e1_valid", 32'(cu_valid), 1);
        tick();
        check_vec("run_e2", 32'({cu_ui, cu_uio}), 32'h2201);
        check_vec("run_e2_valid", 32'(cu_valid), 1);
        tick();
        check_vec("run_end_bus",   32'({cu_ui, cu_uio}), 0);
        check_vec("run_end_valid", 32'(cu_valid), 0);
        check_vec("run_end_busy",  32'(busy),     0);
        check_vec("run_done",      32'(done),     1);
        tick();
        check_vec("run_done_fall", 32'(done),   0);
        check_vec("run_result",    32'(result), 32'hC9);
        wait_idle();
        check_vec("h3_result", 32'(result_h3), 32'hC9);

        // Full buffer: ninth write is dropped, replay issues exactly eight
        do_clear();
        check_vec("clr_count",    32'(count),    0);
        check_vec("clr_wr_ready", 32'(wr_ready), 1);
        for (int i = 0; i < 9; i++) begin
            wr(8'(8'h30 + i), 8'(8'hA0 + i));
            if (i == 7) begin
                check_vec("full_count8",   32'(count),    8);
                check_vec("full_wr_ready", 32'(wr_ready), 0);
            end
        end
        check_vec("full_count9", 32'(count), 8);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            check_vec("full_entry", 32'({cu_ui, cu_uio}), 32'({8'(8'h30 + k), 8'(8'hA0 + k)}));
            check_vec("full_valid", 32'(cu_valid), 1);
            tick();
        end
        check_vec("full_end_valid", 32'(cu_valid), 0);
        check_vec("full_done",      32'(done),     1);
        wait_idle();

        // HOLD_CYCLES=3 with two entries
        do_clear();
        wr(8'h5A, 8'h01);
        wr(8'h5B, 8'h02);
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            check_vec("h3_entry", 32'({cu_ui_h3, cu_uio_h3}), (c < 3) ? 32'h5A01 : 32'h5B02);
            check_vec("h3_busy",  32'(busy_h3), 1);
            check_vec("h3_done_low", 32'(done_h3), 0);
            tick();
        end
        check_vec("h3_end_busy",  32'(busy_h3),     0);
        check_vec("h3_end_valid", 32'(cu_valid_h3), 0);
        check_vec("h3_done",      32'(done_h3),     1);
        tick();
        check_vec("h3_done_fall", 32'(done_h3), 0);
        wait_idle();

        // Start with an empty buffer
        do_clear();
        pulse_start();
        check_vec("empty_valid", 32'(cu_valid), 0);
        check_vec("empty_busy",  32'(busy),     0);
        check_vec("empty_done",  32'(done),     1);
        tick();
        check_vec("empty_done_fall", 32'(done), 0);
        wait_idle();

        // clear beats a same-cycle write
        wr(8'h77, 8'h01);
        check_vec("cw_pre_count", 32'(count), 1);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_op    = 8'h78;
        wr_data  = 8'h02;
        tick();
        clear    = 1'b0;
        wr_valid = 1'b0;
        check_vec("cw_count", 32'(count), 0);

        // ena=0 mid-run freezes the bus for four cycles, replay then resumes
        for (int i = 0; i < 4; i++) wr(8'(8'h40 + i), 8'(8'h90 + i));
        check_vec("ena_load_count", 32'(count), 4);
        pulse_start();
        check_vec("ena_e0", 32'({cu_ui, cu_uio}), 32'h4090);
        tick();
        check_vec("ena_e1", 32'({cu_ui, cu_uio}), 32'h4191);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec("ena_frozen_bus",   32'({cu_ui, cu_uio}), 32'h4191);
            check_vec("ena_frozen_valid", 32'(cu_valid), 1);
        end
        check_vec("ena_frozen_count", 32'(count), 4);
        ena = 1'b1;
        tick();
        check_vec("ena_e2", 32'({cu_ui, cu_uio}), 32'h4292);
        tick();
        check_vec("ena_e3", 32'({cu_ui, cu_uio}), 32'h4393);
        tick();
        check_vec("ena_end_bus", 32'({cu_ui, cu_uio}), 0);
        check_vec("ena_done",    32'(done),     1);
        wait_idle();

        // Reset in the middle of a replay of the retained program
        pulse_start();
        check_vec("mrst_e0", 32'({cu_ui, cu_uio}), 32'h4090);
        tick();
        check_vec("mrst_e1", 32'({cu_ui, cu_uio}), 32'h4191);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("mrst_bus",   32'({cu_ui, cu_uio}), 0);
        check_vec("mrst_valid", 32'(cu_valid), 0);
        check_vec("mrst_busy",  32'(busy),     0);
        check_vec("mrst_count", 32'(count),    0);
        rst_n = 1'b1;
        tick();
        check_vec("mrst_wr_ready", 32'(wr_ready), 1);
        check_vec("mrst_post_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
